// File: rtl/ysyx_22050598_ifu_fbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050598_ifu_fbuf_pkg                                            |
// | Shared types and defaults for the buffered instruction fetch unit.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ysyx_22050598_ifu_fbuf_pkg;

    localparam int          PC_W         = 64;
    localparam int          INST_W       = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [1:0]      epoch;
    } fetch_tag_t;

    // The 64-bit read covers two instructions; pc[2] picks the word.
    function automatic logic [INST_W-1:0] inst_sel(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050598_ifu_fbuf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050598_ifu_fbuf_if                                             |
// | Memory request/response channel and IDU instruction channel.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface ysyx_22050598_ifu_fbuf_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [63:0]     rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [31:0]     inst;

    modport master (
        output req_valid, req_addr, inst_valid, inst_pc, inst,
        input  req_ready, rsp_valid, rsp_data, inst_ready
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst_pc, inst,
        output req_ready, rsp_valid, rsp_data, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050598_gnrl_dffr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050598_gnrl_dffr                                               |
// | Enabled flop with a parameterised asynchronous reset value.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ysyx_22050598_gnrl_dffr #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en,
    input  wire logic [DW-1:0] d,
    output logic      [DW-1:0] q
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/ysyx_22050598_gnrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050598_gnrl_fifo                                               |
// | Generic FIFO with synchronous clear, occupancy count, zero when empty.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ysyx_22050598_gnrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       clr,
    input  wire logic                       wr_en,
    input  wire logic [WIDTH-1:0]           wr_data,
    input  wire logic                       rd_en,
    output logic      [WIDTH-1:0]           rd_data,
    output logic      [$clog2(DEPTH+1)-1:0] count,
    output logic                            empty
);
    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  c_last  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_pop   = rd_en && !empty;
    // A write at full is legal only when the head leaves in the same cycle.
    assign w_push  = wr_en && (!w_full || w_pop);
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && w_full && !rd_en && !clr));
endmodule
`default_nettype wire

// File: rtl/ysyx_22050598_ifu_fbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050598_ifu_fbuf                                                |
// | Fetch unit: PC generation, pipelined aligned reads, fetch buffer.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ysyx_22050598_ifu_fbuf
    import ysyx_22050598_ifu_fbuf_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter int              FB_DEPTH  = 4,
    parameter int              MAX_OUTST = 2
)(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush_pc_en,
    input  wire logic [XLEN-1:0]  flush_pc,
    input  wire logic             prdt_pc_en,
    input  wire logic [XLEN-1:0]  prdt_pc_add_op,
    ysyx_22050598_ifu_fbuf_if.master bus
);
    localparam int                FB_CW       = $clog2(FB_DEPTH + 1);
    localparam int                OS_CW       = $clog2(MAX_OUTST + 1);
    localparam int                SUM_W       = FB_CW + 1;
    localparam logic [SUM_W-1:0]  c_fb_depth  = SUM_W'(FB_DEPTH);
    localparam logic [OS_CW-1:0]  c_max_outst = OS_CW'(MAX_OUTST);
    localparam logic [XLEN-1:0]   c_pc_step   = XLEN'(4);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    logic             w_pc_en;
    logic [1:0]       r_epoch;
    logic [FB_CW-1:0] w_fb_cnt;
    logic [OS_CW-1:0] w_outst_cnt;
    logic             w_fb_empty;
    logic             w_tag_empty;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_take;
    logic             w_fb_push;
    logic             w_fb_pop;
    fetch_tag_t       w_tag_in;
    fetch_tag_t       w_tag_head;
    fetch_entry_t     w_ent_in;
    fetch_entry_t     w_ent_head;

    // Buffer space is reserved at issue, so in-flight reads count against it.
    assign w_req_valid = rst && !flush_pc_en
                      && ((SUM_W'(w_fb_cnt) + SUM_W'(w_outst_cnt)) < c_fb_depth)
                      && (w_outst_cnt < c_max_outst);
    assign w_req_fire  = w_req_valid && bus.req_ready;

    assign w_pc_en  = flush_pc_en || w_req_fire;
    assign w_pc_nxt = flush_pc_en ? flush_pc
                                  : r_pc + (prdt_pc_en ? prdt_pc_add_op : c_pc_step);

    ysyx_22050598_gnrl_dffr #(
        .DW      (XLEN),
        .RST_VAL (RESET_PC)
    ) u_pc_dff (
        .clk (clk),
        .rst (rst),
        .en  (w_pc_en),
        .d   (w_pc_nxt),
        .q   (r_pc)
    );

    // Two epoch bits let stale reads survive back-to-back redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epoch <= '0;
        end else if (flush_pc_en) begin
            r_epoch <= (MAX_OUTST > 1) ? r_epoch + 2'd1 : {1'b0, ~r_epoch[0]};
        end
    end

    assign w_tag_in = '{pc: PC_W'(r_pc), epoch: r_epoch};

    ysyx_22050598_gnrl_fifo #(
        .WIDTH ($bits(fetch_tag_t)),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .wr_en   (w_req_fire),
        .wr_data (w_tag_in),
        .rd_en   (w_rsp_take),
        .rd_data (w_tag_head),
        .count   (w_outst_cnt),
        .empty   (w_tag_empty)
    );

    // Responses with nothing in flight (e.g. after a reset) are dropped.
    assign w_rsp_take = bus.rsp_valid && !w_tag_empty;
    assign w_fb_push  = w_rsp_take && (w_tag_head.epoch == r_epoch);
    assign w_ent_in   = '{pc:   w_tag_head.pc,
                          inst: inst_sel(bus.rsp_data, w_tag_head.pc[2])};
    assign w_fb_pop   = !w_fb_empty && bus.inst_ready;

    ysyx_22050598_gnrl_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FB_DEPTH)
    ) u_fb_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush_pc_en),
        .wr_en   (w_fb_push),
        .wr_data (w_ent_in),
        .rd_en   (w_fb_pop),
        .rd_data (w_ent_head),
        .count   (w_fb_cnt),
        .empty   (w_fb_empty)
    );

    assign bus.req_valid  = w_req_valid;
    assign bus.req_addr   = {r_pc[XLEN-1:3], 3'b000};
    assign bus.inst_valid = !w_fb_empty;
    assign bus.inst_pc    = XLEN'(w_ent_head.pc);
    assign bus.inst       = w_ent_head.inst;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050598_ifu_fbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_22050598_ifu_fbuf                                             |
// | Directed scenarios plus random traffic against a queue-based model.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ysyx_22050598_ifu_fbuf;
    localparam int          XLEN      = 64;
    localparam int          FB_DEPTH  = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [63:0] c_rst_pc  = 64'h8000_0000;

    typedef struct { logic [63:0] pc; int gen; int cyc; } tag_m_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_m_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_pc_en = 1'b0;
    logic [63:0] flush_pc = '0;
    logic        prdt_pc_en = 1'b0;
    logic [63:0] prdt_pc_add_op = '0;

    ysyx_22050598_ifu_fbuf_if #(.XLEN(XLEN)) bus ();

    ysyx_22050598_ifu_fbuf #(
        .XLEN      (XLEN),
        .RESET_PC  (c_rst_pc),
        .FB_DEPTH  (FB_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_pc_en    (flush_pc_en),
        .flush_pc       (flush_pc),
        .prdt_pc_en     (prdt_pc_en),
        .prdt_pc_add_op (prdt_pc_add_op),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    tag_m_t      q_tag[$];
    ent_m_t      q_fb[$];
    logic [63:0] m_pc;
    int          m_gen;
    int          cyc;
    int          n_chk;
    int          n_fail;
    bit          force_rsp;
    logic [63:0] log_addr[$];
    logic [63:0] log_pc[$];
    logic [31:0] log_inst[$];
    logic        s_req_valid;
    logic [63:0] s_req_addr;
    logic        s_inst_valid;

    // Memory contents are a fixed function of the aligned address.
    function automatic logic [63:0] mem_word(input logic [63:0] addr);
        logic [31:0] a;
        a = addr[31:0] & 32'hFFFF_FFF8;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word(pc);
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc  = c_rst_pc;
        m_gen = 0;
        q_tag.delete();
        q_fb.delete();
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_pc.delete();
        log_inst.delete();
    endtask

    task automatic step(input bit rdy, input bit rv, input bit ir, input bit fl,
                        input logic [63:0] fpc, input bit pe, input logic [63:0] op);
        bit     have_rsp, exp_rv, fire, take, pop;
        tag_m_t t;
        @(negedge clk);
        have_rsp = (q_tag.size() > 0) && (q_tag[0].cyc < cyc);
        bus.req_ready  = rdy;
        bus.inst_ready = ir;
        flush_pc_en    = fl;
        flush_pc       = fpc;
        prdt_pc_en     = pe;
        prdt_pc_add_op = op;
        bus.rsp_valid  = force_rsp || (rv && have_rsp);
        bus.rsp_data   = have_rsp ? mem_word(q_tag[0].pc) : {$urandom, $urandom};
        #1;
        exp_rv = ((q_fb.size() + q_tag.size()) < FB_DEPTH) && (q_tag.size() < MAX_OUTST) && !fl;
        s_req_valid  = bus.req_valid;
        s_req_addr   = bus.req_addr;
        s_inst_valid = bus.inst_valid;
        check_eq("req_valid", bus.req_valid, exp_rv);
        if (exp_rv) check_eq("req_addr", bus.req_addr, m_pc & ~64'h7);
        check_eq("inst_valid", bus.inst_valid, q_fb.size() > 0);
        if (q_fb.size() > 0) begin
            check_eq("inst_pc", bus.inst_pc, q_fb[0].pc);
            check_eq("inst", bus.inst, q_fb[0].inst);
        end
        if (bus.req_valid && rdy) log_addr.push_back(bus.req_addr);
        if (bus.inst_valid && ir && !fl) begin
            log_pc.push_back(bus.inst_pc);
            log_inst.push_back(bus.inst);
        end
        fire = exp_rv && rdy;
        take = bus.rsp_valid && (q_tag.size() > 0);
        pop  = (q_fb.size() > 0) && ir;
        @(posedge clk);
        if (take) t = q_tag.pop_front();
        if (fl) begin
            q_fb.delete();
            m_gen++;
            m_pc = fpc;
        end else begin
            if (pop) void'(q_fb.pop_front());
            if (take && t.gen == m_gen) q_fb.push_back('{pc: t.pc, inst: exp_inst(t.pc)});
            if (fire) begin
                q_tag.push_back('{pc: m_pc, gen: m_gen, cyc: cyc});
                m_pc = m_pc + (pe ? op : 64'd4);
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        bit          rdy, rv, ir, fl, pe, ok;
        logic [63:0] fpc, op;
        n_chk = 0; n_fail = 0; cyc = 0; force_rsp = 1'b0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.inst_ready = 1'b0;
        model_reset();
        clear_logs();

        // Reset state
        #12;
        check_eq("rst_req_valid", bus.req_valid, 1'b0);
        check_eq("rst_inst_valid", bus.inst_valid, 1'b0);
        check_eq("rst_inst_pc", bus.inst_pc, 64'h0);
        check_eq("rst_inst", bus.inst, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Streaming with 1-cycle memory and an always-ready IDU
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("s1_n", (log_addr.size() >= 3) && (log_pc.size() >= 3), 1'b1);
        if (log_addr.size() >= 3 && log_pc.size() >= 3) begin
            check_eq("s1_addr0", log_addr[0], 64'h8000_0000);
            check_eq("s1_addr1", log_addr[1], 64'h8000_0000);
            check_eq("s1_addr2", log_addr[2], 64'h8000_0008);
            check_eq("s1_pc0", log_pc[0], 64'h8000_0000);
            check_eq("s1_pc1", log_pc[1], 64'h8000_0004);
            check_eq("s1_pc2", log_pc[2], 64'h8000_0008);
            check_eq("s1_inst0", log_inst[0], 32'h7FFF_FFFF);
            check_eq("s1_inst1", log_inst[1], 32'hDA5A_0000);
            check_eq("s1_inst2", log_inst[2], 32'h7FFF_FFF7);
        end

        // IDU stalled: buffer fills to FB_DEPTH, then drains in order
        drain();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        check_eq("s2_full_req", s_req_valid, 1'b0);
        check_eq("s2_full_valid", s_inst_valid, 1'b1);
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("s2_drain_cnt", log_pc.size(), 64'd4);

        // Flush with two reads outstanding
        drain();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        clear_logs();
        step(1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_1000, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("s3_n", log_pc.size() >= 1, 1'b1);
        if (log_pc.size() >= 1) begin
            check_eq("s3_pc0", log_pc[0], 64'h8000_1000);
            check_eq("s3_inst0", log_inst[0], 32'h7FFF_EFFF);
        end

        // Predicted backward step of -8
        drain();
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b0, '0);
        clear_logs();
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("s4_n", (log_addr.size() >= 2) && (log_pc.size() >= 2), 1'b1);
        if (log_addr.size() >= 2 && log_pc.size() >= 2) begin
            check_eq("s4_addr0", log_addr[0], 64'h8000_0010);
            check_eq("s4_addr1", log_addr[1], 64'h8000_0008);
            check_eq("s4_pc1", log_pc[1], 64'h8000_0008);
            check_eq("s4_inst1", log_inst[1], 32'h7FFF_FFF7);
        end

        // Flush coinciding with a response and a pop
        drain();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_2000, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("s5_empty", s_inst_valid, 1'b0);
        check_eq("s5_req_valid", s_req_valid, 1'b1);
        check_eq("s5_req_addr", s_req_addr, 64'h8000_2000);

        // Asynchronous reset while reads are in flight
        drain();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("mrst_req_valid", bus.req_valid, 1'b0);
        check_eq("mrst_inst_valid", bus.inst_valid, 1'b0);
        check_eq("mrst_inst_pc", bus.inst_pc, 64'h0);
        check_eq("mrst_inst", bus.inst, 64'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        force_rsp = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        force_rsp = 1'b0;
        check_eq("mrst_late_valid", s_inst_valid, 1'b0);
        check_eq("mrst_addr", s_req_addr, 64'h8000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 3) != 0;
            ir  = ($urandom % 4) != 0;
            pe  = ($urandom % 4) == 0;
            op  = 64'(($signed(32'($urandom_range(0, 15))) - 32'sd8) * 32'sd4);
            fpc = {$urandom, $urandom} & ~64'h3;
            ok  = 1'b1;
            foreach (q_tag[k]) if (m_gen - q_tag[k].gen > 2) ok = 1'b0;
            fl  = ok && (($urandom % 32) == 0);
            step(rdy, rv, ir, fl, fpc, pe, op);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
